// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, segment bit order and hex decode helpers for the 7-segment scanner.
package seg7_pkg;

    localparam int         SEG7_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK   = 8'h00;

    // Bit positions within seg_out, {dp,g,f,e,d,c,b,a}
    typedef enum logic [2:0] {
        SEG_A  = 3'd0,
        SEG_B  = 3'd1,
        SEG_C  = 3'd2,
        SEG_D  = 3'd3,
        SEG_E  = 3'd4,
        SEG_F  = 3'd5,
        SEG_G  = 3'd6,
        SEG_DP = 3'd7
    } seg_bit_e;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Digit i is a leading zero when nibbles i..7 are all zero; digit 0 and dp digits stay lit.
    function automatic logic [7:0] lz_mask(input logic [31:0] num, input logic [7:0] dp);
        logic [7:0] m;
        logic       z;
        m = '0;
        z = 1'b1;
        for (int i = SEG7_DIGITS - 1; i > 0; i--) begin
            z    = z & (num[4*i +: 4] == 4'h0);
            m[i] = z & ~dp[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-high gfedcba segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed 7-segment scanner with frame-synchronous input shadowing.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int BLINK_BIT  = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] disp_num,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  blink_en,
    output logic [7:0]  seg_out,
    output logic [7:0]  an_out,
    output logic        frame_sync
);

    localparam logic [7:0] POL = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic [31:0]      num_s_q;
    logic [7:0]       dp_s_q, en_s_q, bl_s_q;
    logic [7:0]       an_q, an_d, seg_q, seg_d;
    logic             fs_q;
    logic             tick, frame_end, blank, lz_blank;
    logic [3:0]       nib;
    logic [6:0]       pat;

    assign tick      = &cnt_q;
    assign frame_end = tick & (idx_q == 3'(SEG7_DIGITS - 1));

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        idx_d  = tick ? idx_q + 3'd1 : idx_q;
        fcnt_d = frame_end ? fcnt_q + 8'd1 : fcnt_q;
    end

    assign nib = num_s_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (pat)
    );

`ifdef SEG7_LZB_EN
    logic [7:0] lz_q;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            lz_q <= '0;
        else if (frame_end)
            lz_q <= lz_mask(disp_num, dp_in);
    end
    assign lz_blank = lz_q[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    // Last cycle of each slot is dark so the anode switch never shows the previous digit.
    always_comb begin
        blank = ~en_s_q[idx_q] | (bl_s_q[idx_q] & fcnt_q[BLINK_BIT]) | tick | lz_blank;
        seg_d = (blank ? SEG_BLANK : {dp_s_q[idx_q], pat}) ^ POL;
        an_d  = (blank ? 8'h00 : 8'h01 << idx_q) ^ POL;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            num_s_q <= '0;
            dp_s_q  <= '0;
            en_s_q  <= '0;
            bl_s_q  <= '0;
            an_q    <= POL;
            seg_q   <= POL;
            fs_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            fcnt_q <= fcnt_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            fs_q   <= frame_end;
            if (frame_end) begin
                num_s_q <= disp_num;
                dp_s_q  <= dp_in;
                en_s_q  <= digit_en;
                bl_s_q  <= blink_en;
            end
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_sync = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scanning, shadowing, blanking, blink and reset (DIV_W=2).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] disp_num;
    logic [7:0]  dp_in, digit_en, blink_en;
    logic [7:0]  seg_out, an_out;
    logic        frame_sync;
    int          total = 0, passed = 0, pos = 0, fr = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIV_W(2), .ACTIVE_LOW(1'b1), .BLINK_BIT(1)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .disp_num   (disp_num),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blink_en   (blink_en),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_sync (frame_sync)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_sync && k < 64);
        check("frame_sync_seen", frame_sync, 1'b1);
        pos = 0;
        fr++;
    endtask

    task automatic at(input int n);
        repeat (n - pos) @(negedge clk);
        pos = n;
    endtask

    task automatic digit(input string tag, input int d, input logic [7:0] an_e, input logic [7:0] seg_e);
        at(4 * d + 2);
        check({tag, "_an"}, an_out, an_e);
        check({tag, "_seg"}, seg_out, seg_e);
    endtask

    // Release reset on a falling edge and count cycles to the first frame_sync.
    task automatic release_reset();
        int k = 0;
        @(negedge clk);
        clrn = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (k == 18) check("frame0_an", an_out, 8'hFF);
        end while (!frame_sync && k < 64);
        check("first_sync_cycles", k, 32);
        pos = 0;
        fr = 1;
    endtask

    initial begin
        disp_num = 32'h76543210;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        blink_en = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_an", an_out, 8'hFF);
        check("rst_seg", seg_out, 8'hFF);
        check("rst_fs", frame_sync, 1'b0);
        release_reset();

        at(1);
        check("fs_one_cycle", frame_sync, 1'b0);
        digit("d0", 0, 8'hFE, 8'hC0);
        at(4);
        check("slot_edge_blank", an_out, 8'hFF);
        digit("d5", 5, 8'hDF, 8'h92);
        disp_num = 32'hFFFFFFFF;
        digit("d6_old_word", 6, 8'hBF, 8'h82);

        wait_frame();
        digit("d0_F", 0, 8'hFE, 8'h8E);
        digit("d7_F", 7, 8'h7F, 8'h8E);
        digit_en = 8'h0F;
        dp_in    = 8'h01;

        wait_frame();
        digit("d0_dp", 0, 8'hFE, 8'h0E);
        digit("d3_en", 3, 8'hF7, 8'h8E);
        digit("d4_dis", 4, 8'hFF, 8'hFF);
        digit("d7_dis", 7, 8'hFF, 8'hFF);
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        blink_en = 8'h01;

        // fcnt runs 4,5 (lit) then 6,7 (dark) over these frames
        for (int f = 0; f < 4; f++) begin
            wait_frame();
            digit("blink_d0", 0, fr[1] ? 8'hFF : 8'hFE, fr[1] ? 8'hFF : 8'h8E);
            digit("blink_d1", 1, 8'hFD, 8'h8E);
        end

        at(9);
        check("pre_rst_lit", an_out, 8'hFB);
        clrn = 1'b0;
        #1;
        check("mid_rst_an", an_out, 8'hFF);
        check("mid_rst_seg", seg_out, 8'hFF);
        check("mid_rst_fs", frame_sync, 1'b0);
        disp_num = 32'h00000305;
        blink_en = 8'h00;
        release_reset();

`ifdef SEG7_LZB_EN
        digit("lz_d0", 0, 8'hFE, 8'h92);
        digit("lz_d1", 1, 8'hFD, 8'hC0);
        digit("lz_d2", 2, 8'hFB, 8'hB0);
        digit("lz_d3", 3, 8'hFF, 8'hFF);
        digit("lz_d7", 7, 8'hFF, 8'hFF);
        disp_num = 32'h0;
        wait_frame();
        digit("lz0_d0", 0, 8'hFE, 8'hC0);
        digit("lz0_d1", 1, 8'hFD ^ 8'h02, 8'hFF);
`else
        digit("nolz_d0", 0, 8'hFE, 8'h92);
        digit("nolz_d2", 2, 8'hFB, 8'hB0);
        digit("nolz_d3", 3, 8'hF7, 8'hC0);
        digit("nolz_d7", 7, 8'h7F, 8'hC0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
